// File: rtl/mips_core_pkg.sv
// Shared core package: bus widths, cache line geometry and the refill FSM state type.
package mips_core_pkg;

    localparam int unsigned ADDR_WIDTH       = 32;
    localparam int unsigned DATA_WIDTH       = 32;
    localparam int unsigned CACHE_LINE_WORDS = 4;
    localparam int unsigned AXI_ID_WIDTH     = 4;
    localparam int unsigned AXI_LEN_WIDTH    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } refill_state_t;

endpackage

// File: rtl/cache_refill_reader_if.sv
// AXI read-address and read-data channel bundles used by the refill reader.
interface axi_read_address;
    logic                                     arvalid;
    logic                                     arready;
    logic [mips_core_pkg::AXI_ID_WIDTH-1:0]   arid;
    logic [mips_core_pkg::AXI_LEN_WIDTH-1:0]  arlen;
    logic [mips_core_pkg::ADDR_WIDTH-1:0]     araddr;

    modport master (output arvalid, arid, arlen, araddr, input arready);
    modport slave  (input arvalid, arid, arlen, araddr, output arready);
endinterface

interface axi_read_data;
    logic                                     rvalid;
    logic                                     rready;
    logic                                     rlast;
    logic [mips_core_pkg::AXI_ID_WIDTH-1:0]   rid;
    logic [mips_core_pkg::DATA_WIDTH-1:0]     rdata;

    modport master (input rvalid, rlast, rid, rdata, output rready);
    modport slave  (output rvalid, rlast, rid, rdata, input rready);
endinterface

// File: rtl/cache_refill_reader.sv
// Single-outstanding AXI burst reader that refills one cache line per request.
// Optional CACHE_REFILL_PROTOCOL_CHECK_EN adds a sticky proto_err output and RLAST/RID/AR assertions.
module cache_refill_reader
    import mips_core_pkg::*;
#(
    parameter int unsigned LINE_WORDS = CACHE_LINE_WORDS,
    parameter logic [3:0]  AXI_ID     = 4'd0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    output logic                             resp_valid,
    input  logic                             resp_ready,
    output logic [LINE_WORDS*DATA_WIDTH-1:0] resp_data,
    axi_read_address.master                  ar,
    axi_read_data.master                     r
`ifdef CACHE_REFILL_PROTOCOL_CHECK_EN
    ,
    output logic                             proto_err
`endif
);

    localparam int unsigned CNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int unsigned OFF_W = $clog2(LINE_WORDS) + 2;

    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_ADDR = 2'(ADDR);
    localparam logic [1:0] ST_DATA = 2'(DATA);
    localparam logic [1:0] ST_RESP = 2'(RESP);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_WORDS - 1);

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic                  arvalid_q;
    logic                  rready_q;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic [CNT_W-1:0]      cnt_q;

    logic req_fire_c;
    logic ar_fire_c;
    logic beat_c;
    logic last_beat_c;
    logic resp_fire_c;

    assign req_fire_c  = req_valid && req_ready;
    assign ar_fire_c   = arvalid_q && ar.arready;
    assign beat_c      = r.rvalid && rready_q;
    assign last_beat_c = (cnt_q == LAST_CNT);
    assign resp_fire_c = resp_valid && resp_ready;

    assign ar.arvalid = arvalid_q;
    assign ar.araddr  = araddr_q;
    assign ar.arid    = AXI_ID;
    assign ar.arlen   = AXI_LEN_WIDTH'(LINE_WORDS - 1);
    assign r.rready   = rready_q;

    // Next-state: completion of the burst is decided purely by the beat counter.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_fire_c)            state_d = ST_ADDR;
            ST_ADDR: if (ar_fire_c)             state_d = ST_DATA;
            ST_DATA: if (beat_c && last_beat_c) state_d = ST_RESP;
            ST_RESP: if (resp_fire_c)           state_d = ST_IDLE;
            default:                            state_d = ST_IDLE;
        endcase
    end

    // State register with handshake outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            req_ready  <= 1'b1;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            resp_valid <= 1'b0;
            araddr_q   <= '0;
            cnt_q      <= '0;
            resp_data  <= '0;
        end else begin
            state_q    <= state_d;
            req_ready  <= (state_d == ST_IDLE);
            arvalid_q  <= (state_d == ST_ADDR);
            rready_q   <= (state_d == ST_DATA);
            resp_valid <= (state_d == ST_RESP);
            if (req_fire_c) begin
                araddr_q <= {req_addr[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
                cnt_q    <= '0;
            end
            if (beat_c) begin
                resp_data[cnt_q*DATA_WIDTH +: DATA_WIDTH] <= r.rdata;
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

`ifdef CACHE_REFILL_PROTOCOL_CHECK_EN
    // Sticky flag for beats whose RLAST or RID disagrees with the expected burst shape.
    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err <= 1'b0;
        end else if (beat_c && ((r.rlast != last_beat_c) || (r.rid != AXI_ID))) begin
            proto_err <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    a_rlast: assert property (@(posedge clk) disable iff (rst) beat_c |-> (r.rlast == last_beat_c));
    a_rid: assert property (@(posedge clk) disable iff (rst) beat_c |-> (r.rid == AXI_ID));
    a_ar_hold: assert property (@(posedge clk) disable iff (rst)
        (arvalid_q && !ar.arready) |=> (arvalid_q && $stable(araddr_q)));
`endif
`endif

endmodule
